mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbiter and sequencer for the single-port unified instruction/data memory of the 8-bit pipelined core. It shares the memory port between the IF stage (instruction fetch at PC) and the MEM stage, which drives its requests from the EX/MEM pipeline register outputs (MemRead/MemWrite, ALU result as address, forwarded store data). It returns read data to the owning stage and produces the stall signals that freeze the losing stage. A bounded-run fairness counter keeps fetch from starving.

## Interface
Parameters:
- AW, 8, address width.
- DW, 8, data width.
- MAX_MEM_RUN, 4, maximum consecutive MEM grants while a fetch waits (≥1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request.
- if_addr  in  AW  fetch address (PC).
- mem_rd  in  1  data read request (EX/MEM MemRead).
- mem_wr  in  1  data write request (EX/MEM MemWrite).
- mem_addr  in  AW  data address (EX/MEM ALU result).
- mem_wdata  in  DW  store data (EX/MEM forwarded value).
- ram_en  out  1  memory access enable.
- ram_we  out  1  memory write enable.
- ram_addr  out  AW  memory address.
- ram_wdata  out  DW  memory write data.
- ram_rdata  in  DW  memory read data, valid the cycle after a read.
- if_grant  out  1  fetch owns the port this cycle.
- mem_grant  out  1  MEM stage owns the port this cycle.
- if_rvalid  out  1  if_rdata valid.
- if_rdata  out  DW  fetched instruction byte.
- mem_rvalid  out  1  mem_rdata valid.
- mem_rdata  out  DW  loaded data byte.
- stall_if  out  1  freeze PC and IF/ID.
- stall_mem  out  1  freeze EX/MEM and all earlier stages.
- err_rw  out  1  one-cycle flag: mem_rd and mem_wr both high.

## Operation
- mem_req = mem_rd | mem_wr. If both are high, a write is performed and err_rw = 1 in that cycle (combinational).
- Grant (combinational, same cycle):
  - mem_req & !force_if: mem_grant = 1.
  - Otherwise if if_req: if_grant = 1.
  - Neither requesting: no grant, ram_en = 0.
- force_if = (run_cnt == MAX_MEM_RUN) & if_req & mem_req.
- run_cnt (registered, width clog2(MAX_MEM_RUN+1)):
  - +1 when mem_grant & if_req, saturating at MAX_MEM_RUN.
  - Cleared when if_grant, or when if_req = 0.
- Port mux: the granted requester drives ram_addr. ram_we = mem_grant & mem_wr. ram_wdata = mem_wdata. With no grant, ram_addr and ram_wdata = 0.
- Stalls: stall_if = if_req & !if_grant; stall_mem = mem_req & !mem_grant.
- Read return: registered tags rd_if <= if_grant and rd_mem <= mem_grant & !mem_wr.
  - if_rvalid = rd_if, mem_rvalid = rd_mem.
  - if_rdata = rd_if ? ram_rdata : 0; mem_rdata = rd_mem ? ram_rdata : 0.
- Writes produce no rvalid.

## Timing
- Grant, ram_* and stalls resolve in the request cycle N. Read data/valid appear in cycle N+1. Back-to-back accesses are allowed every cycle.
- While rst is high: run_cnt = 0 and rd_if = rd_mem = 0. All outputs read 0 (grants, ram_en, ram_we, stalls, rvalids, rdata, err_rw forced low regardless of inputs).
- Reset asserted mid-read: the pending rvalid is dropped. The first cycle after deassertion behaves as from a fresh reset.
- Simultaneous requests: the MEM stage wins unless force_if is set. With both requests held continuously, the pattern is MAX_MEM_RUN MEM grants, then 1 fetch grant, repeating.
- Requesters hold their request and address stable until granted. The arbiter does not latch requests.

## Test plan
- Reset: assert rst mid-run with mem_rd = 1 → all outputs 0 immediately. After release with only if_req = 1, if_addr = 8'h10: if_grant = 1, ram_addr = 8'h10. Next cycle if_rvalid = 1, if_rdata = ram_rdata.
- Conflict: if_req = 1, mem_rd = 1, mem_addr = 8'h80 → mem_grant = 1, stall_if = 1, ram_addr = 8'h80. Next cycle mem_rvalid = 1, if_rvalid = 0.
- Store: mem_wr = 1, mem_addr = 8'h40, mem_wdata = 8'hA5 → ram_we = 1, ram_wdata = 8'hA5. Next cycle mem_rvalid = 0.
- Fairness: if_req and mem_rd held high for 10 cycles with MAX_MEM_RUN = 4 → grants M,M,M,M,F,M,M,M,M,F. stall_mem = 1 exactly on the F cycles.
- Counter clear: 3 MEM grants with if_req high, then if_req low for 1 cycle, then both high → 4 further MEM grants occur before the forced fetch.
- Illegal op: mem_rd = mem_wr = 1 → err_rw = 1, ram_we = 1, mem_rvalid = 0 on the next cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single-port unified instruction/data memory between the IF
//   stage (fetch at PC) and the MEM stage (EX/MEM load/store). MEM wins a
//   conflict unless fetch has waited through MAX_MEM_RUN consecutive MEM
//   grants, in which case fetch is forced through for one cycle. Read data
//   returns one cycle after the grant, tagged to the owning stage.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   if_req, if_addr              fetch request and PC
//   mem_rd, mem_wr, mem_addr,
//   mem_wdata                    data request from EX/MEM
//   ram_en, ram_we, ram_addr,
//   ram_wdata, ram_rdata         memory port (rdata valid the cycle after a read)
//   if_grant, mem_grant          current owner of the port
//   if_rvalid, if_rdata          returned instruction byte
//   mem_rvalid, mem_rdata        returned load byte
//   stall_if, stall_mem          freeze signals for the losing stage
//   err_rw                       mem_rd and mem_wr asserted together
module mem_port_arbiter #(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int MAX_MEM_RUN = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          mem_rd,
  input  logic          mem_wr,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          if_grant,
  output logic          mem_grant,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  output logic          mem_rvalid,
  output logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          err_rw
);

  localparam int CW = (MAX_MEM_RUN < 1) ? 1 : $clog2(MAX_MEM_RUN + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(MAX_MEM_RUN);

  logic [CW-1:0] run_cnt_r;
  logic          rd_if_r;
  logic          rd_mem_r;

  logic          mem_req_s;
  logic          force_if_s;
  logic          if_grant_s;
  logic          mem_grant_s;

  // Grant decision; everything is held low while reset is asserted.
  always_comb begin
    mem_req_s   = 1'b0;
    force_if_s  = 1'b0;
    if_grant_s  = 1'b0;
    mem_grant_s = 1'b0;
    if (rst) begin
      mem_req_s   = 1'b0;
    end else begin
      mem_req_s  = mem_rd | mem_wr;
      // Fetch has waited long enough: let it through this cycle.
      force_if_s = (run_cnt_r == RUN_MAX) & if_req & mem_req_s;
      if (mem_req_s && !force_if_s) begin
        mem_grant_s = 1'b1;
      end else if (if_req) begin
        if_grant_s = 1'b1;
      end else begin
        if_grant_s = 1'b0;
      end
    end
  end

  // Port mux and stall/flag outputs derived from the grant.
  always_comb begin
    ram_addr  = {AW{1'b0}};
    ram_wdata = {DW{1'b0}};
    if (mem_grant_s) begin
      ram_addr  = mem_addr;
      ram_wdata = mem_wdata;
    end else if (if_grant_s) begin
      ram_addr  = if_addr;
      ram_wdata = mem_wdata;
    end else begin
      ram_addr  = {AW{1'b0}};
      ram_wdata = {DW{1'b0}};
    end
  end

  assign if_grant   = if_grant_s;
  assign mem_grant  = mem_grant_s;
  assign ram_en     = if_grant_s | mem_grant_s;
  // A simultaneous rd+wr is executed as a write.
  assign ram_we     = mem_grant_s & mem_wr;
  assign stall_if   = ~rst & if_req & ~if_grant_s;
  assign stall_mem  = mem_req_s & ~mem_grant_s;
  assign err_rw     = ~rst & mem_rd & mem_wr;

  assign if_rvalid  = rd_if_r;
  assign mem_rvalid = rd_mem_r;
  assign if_rdata   = rd_if_r  ? ram_rdata : {DW{1'b0}};
  assign mem_rdata  = rd_mem_r ? ram_rdata : {DW{1'b0}};

  // Read-return tags and the fairness run counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt_r <= {CW{1'b0}};
      rd_if_r   <= 1'b0;
      rd_mem_r  <= 1'b0;
    end else begin
      rd_if_r  <= if_grant_s;
      rd_mem_r <= mem_grant_s & ~mem_wr;
      // Counts MEM grants taken while fetch waits; any fetch grant or a
      // cycle without a fetch request restarts the run.
      if (if_grant_s || !if_req) begin
        run_cnt_r <= {CW{1'b0}};
      end else if (mem_grant_s && (run_cnt_r != RUN_MAX)) begin
        run_cnt_r <= run_cnt_r + CW'(1);
      end else begin
        run_cnt_r <= run_cnt_r;
      end
    end
  end

endmodule
